pmod_cal_engine: RTL and testbench
==================================

# pmod_cal_engine

Parametrised, time-multiplexed calibration engine for the calibrated-sample path between the AK4619 CODEC driver and user DSP logic. It generalises the fixed 4-in/4-out calibrator to N_IN input and N_OUT output channels. It adds the following:
- a runtime-writable per-channel offset/gain table;
- jack-gated input muting and DAC force mode;
- coherent, all-channels-at-once output commit per sample frame.

One shared subtract/multiply/saturate datapath processes one channel per cycle.

## Interface
- `W`, 16: sample width, bits.
- `N_IN`, 4: input (ADC) channel count.
- `N_OUT`, 4: output (DAC) channel count.
- `CAL_W`, 16: signed gain/offset width. Unity gain = 2^(CAL_W-2).
- N = N_IN+N_OUT; `AW` = $clog2(N) (derived).

- `clk_256fs` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `strobe` in 1: one-cycle frame start, from CODEC driver.
- `adc_raw` in N_IN*W: raw ADC samples, channel c at [c*W +: W], signed.
- `dac_user` in N_OUT*W: user DAC samples, signed.
- `jack` in N_IN: 1 = jack inserted.
- `force_dac_en` in 1: override DAC outputs.
- `force_dac_value` in W: override value.
- `cfg_we` in 1: coefficient table write.
- `cfg_addr` in AW: channel index. Inputs are 0..N_IN-1; outputs are N_IN..N-1.
- `cfg_offset` in CAL_W: signed offset.
- `cfg_gain` in CAL_W: signed gain.
- `cal_in` out N_IN*W: calibrated inputs to DSP.
- `dac_out` out N_OUT*W: calibrated samples to CODEC.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse, outputs committed.
- `overrun` out 1: one-cycle pulse, strobe arrived while busy.

## Operation
- States: IDLE, RUN, DRAIN. Pipeline is S1 (subtract) and S2 (multiply, shift, saturate, mask) into a result buffer.
- IDLE + strobe:
  - snapshot `adc_raw`, `dac_user`, `jack`, `force_dac_en`, `force_dac_value`;
  - idx=0; enter RUN; busy=1.
- RUN issues channel idx per cycle and increments idx. After idx=N-1, go to DRAIN.
- DRAIN waits for the pipeline to empty. It then commits the result buffer to `cal_in`/`dac_out`, pulses `done`, and returns to IDLE.
- Channel source x:
  - input c: bitwise ~adc_raw[c] (analog frontend inverts);
  - output c: dac_user[c-N_IN].
- Arithmetic:
  - d = x - offset, W+1 bits;
  - p = d*gain, W+CAL_W+1 bits, signed;
  - y = p >>> (CAL_W-2), arithmetic;
  - clamp y to [-2^(W-1), 2^(W-1)-1].
- Input channel with snapshot jack[c]=0: result 0.
- Output channels with snapshot force_dac_en=1: result = force_dac_value, with no calibration or saturation.
- Coefficient reads happen at the channel's issue cycle. A `cfg_we` to the channel issued in the same cycle: the old value is used and the new value is stored. Writes are accepted in any state.
- `strobe` while busy: ignored, and `overrun` pulses for one cycle. Frame continues unaffected.
- Reset values:
  - all `cal_in`/`dac_out` 0; busy, done, overrun 0; state IDLE;
  - offsets 0; gains 2^(CAL_W-2);
  - snapshot and pipeline registers 0.
- `rst_n` low mid-frame aborts immediately. No commit occurs and no done pulse is generated.

## Timing
- E0 = edge sampling strobe=1: snapshot loaded and busy=1 after E0.
- Channel k:
  - S1 at E(k+1);
  - S2/result buffer at E(k+2).
- Commit edge E(N+2):
  - all outputs update simultaneously;
  - done=1 for the cycle after E(N+2);
  - busy=0 after E(N+2).
- Latency: strobe to outputs is N+2 edges; default N=8 gives 10.
- Minimum strobe spacing is N+3 cycles; a strobe sampled at E(N+2) is overrun.
- `cal_in`/`dac_out` are stable between commits.

## Test plan
- Reset: hold rst_n=0, then release with no strobe.
  -> all outputs 0, busy=0, done=0 indefinitely.
- Unity defaults, jack=4'hF, adc_raw ch0=16'h0FFF, strobe at E0.
  -> cal_in ch0 = -4096 (16'hF000) at E10.
  -> done pulse in cycle after E10 only.
  -> busy high E0..E10.
- cfg ch4 offset=100, gain=24576; dac_user ch0=1100.
  -> dac_out ch0=1500.
- cfg ch5 gain=32767 with dac_user ch1=30000.
  -> dac_out ch1=32767.
- cfg ch6 gain=32767 with dac_user ch2=-30000.
  -> dac_out ch2=-32768.
- jack=4'b1101, adc_raw ch1=16'h8000.
  -> cal_in ch1=0.
  -> other input channels calibrated normally.
- force_dac_en=1, force_dac_value=1234, arbitrary dac_user and cfg.
  -> all four dac_out=1234.
  -> cal_in unaffected.
- Second strobe at E3.
  -> overrun pulse one cycle; results of the first frame unchanged; no second done.
- rst_n low at E5.
  -> outputs 0, busy 0, table reset.
  -> next strobe completes normally with unity results.

Source files
------------

// File: rtl/pmod_cal_engine.sv
// pmod_cal_engine: time-multiplexed offset/gain calibrator for CODEC in/out channels
// with one shared datapath and an all-channels-at-once commit per frame.
module pmod_cal_engine #(
  parameter int W = 16,
  parameter int N_IN = 4,
  parameter int N_OUT = 4,
  parameter int CAL_W = 16,
  localparam int N = N_IN + N_OUT,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk_256fs,
  input  logic                  rst_n,
  input  logic                  strobe,
  input  logic [N_IN*W-1:0]     adc_raw,
  input  logic [N_OUT*W-1:0]    dac_user,
  input  logic [N_IN-1:0]       jack,
  input  logic                  force_dac_en,
  input  logic [W-1:0]          force_dac_value,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [CAL_W-1:0]      cfg_offset,
  input  logic [CAL_W-1:0]      cfg_gain,
  output logic [N_IN*W-1:0]     cal_in,
  output logic [N_OUT*W-1:0]    dac_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int PW = W + CAL_W + 1;
  localparam logic signed [PW-1:0] HI = PW'((2 ** (W - 1)) - 1);
  localparam logic signed [PW-1:0] LO = ~HI;
  localparam logic signed [CAL_W-1:0] UNITY = CAL_W'(2 ** (CAL_W - 2));
  state_t state;
  logic [AW-1:0] idx, s1_ch;
  logic signed [W-1:0] src_s [N];
  logic [N-1:0] zero_s, force_s;
  logic [W-1:0] fval_s;
  logic [W-1:0] res [N];
  logic signed [CAL_W-1:0] off_t [N];
  logic signed [CAL_W-1:0] gain_t [N];
  logic signed [CAL_W-1:0] s1_g;
  logic signed [W:0] s1_d;
  logic s1_v, s1_zero, s1_force;
  logic signed [PW-1:0] p, y;
  logic [W-1:0] sat, r;
  always_comb begin
    p = PW'(s1_d) * PW'(s1_g);
    y = p >>> (CAL_W - 2);
    sat = y > HI ? HI[W-1:0] : y < LO ? LO[W-1:0] : y[W-1:0];
    r = s1_zero ? '0 : s1_force ? fval_s : sat;
  end
  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
      cal_in <= '0;
      dac_out <= '0;
      zero_s <= '0;
      force_s <= '0;
      fval_s <= '0;
      s1_v <= 1'b0;
      s1_ch <= '0;
      s1_d <= '0;
      s1_g <= '0;
      s1_zero <= 1'b0;
      s1_force <= 1'b0;
      for (int c = 0; c < N; c++) begin
        src_s[c] <= '0;
        res[c] <= '0;
        off_t[c] <= '0;
        gain_t[c] <= UNITY;
      end
    end else begin
      done <= 1'b0;
      overrun <= strobe && state != IDLE;
      s1_v <= 1'b0;
      if (cfg_we && int'(cfg_addr) < N) begin
        off_t[cfg_addr] <= cfg_offset;
        gain_t[cfg_addr] <= cfg_gain;
      end
      if (s1_v) res[s1_ch] <= r;
      case (state)
        IDLE: if (strobe) begin
          // the analog frontend inverts, so inputs are stored already un-inverted
          for (int c = 0; c < N_IN; c++) src_s[c] <= ~adc_raw[c*W +: W];
          for (int c = 0; c < N_OUT; c++) src_s[N_IN + c] <= dac_user[c*W +: W];
          zero_s <= {{N_OUT{1'b0}}, ~jack};
          force_s <= {{N_OUT{force_dac_en}}, {N_IN{1'b0}}};
          fval_s <= force_dac_value;
          idx <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          s1_v <= 1'b1;
          s1_ch <= idx;
          s1_d <= (W+1)'(src_s[idx]) - (W+1)'(off_t[idx]);
          s1_g <= gain_t[idx];
          s1_zero <= zero_s[idx];
          s1_force <= force_s[idx];
          idx <= idx + 1'b1;
          if (idx == AW'(N - 1)) state <= DRAIN;
        end
        default: if (!s1_v) begin
          for (int c = 0; c < N_IN; c++) cal_in[c*W +: W] <= res[c];
          for (int c = 0; c < N_OUT; c++) dac_out[c*W +: W] <= res[N_IN + c];
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pmod_cal_engine.sv
// tb_pmod_cal_engine: scoreboard bench for pmod_cal_engine at default parameters.
module tb_pmod_cal_engine;
  logic clk_256fs = 1'b0, rst_n = 1'b0, strobe = 1'b0, force_dac_en = 1'b0, cfg_we = 1'b0;
  logic [63:0] adc_raw = '0, dac_user = '0;
  logic [3:0] jack = '0;
  logic [15:0] force_dac_value = '0, cfg_offset = '0, cfg_gain = '0;
  logic [2:0] cfg_addr = '0;
  logic [63:0] cal_in, dac_out;
  logic busy, done, overrun;
  typedef struct { logic [63:0] ci; logic [63:0] dout; } exp_t;
  exp_t sb[$];
  int off_m[8], gain_m[8];
  int passed = 0, total = 0;

  pmod_cal_engine dut (
    .clk_256fs(clk_256fs), .rst_n(rst_n), .strobe(strobe), .adc_raw(adc_raw),
    .dac_user(dac_user), .jack(jack), .force_dac_en(force_dac_en),
    .force_dac_value(force_dac_value), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_offset(cfg_offset), .cfg_gain(cfg_gain), .cal_in(cal_in), .dac_out(dac_out),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk_256fs = ~clk_256fs;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_256fs);
    #1;
  endtask

  function automatic void reset_model;
    for (int c = 0; c < 8; c++) begin
      off_m[c] = 0;
      gain_m[c] = 16384;
    end
  endfunction

  function automatic logic [15:0] cal(input int ch, input logic [15:0] x);
    longint y;
    y = ((longint'($signed(x)) - longint'(off_m[ch])) * longint'(gain_m[ch])) >>> 14;
    y = y > 32767 ? 32767 : y < -32768 ? -32768 : y;
    return 16'(y);
  endfunction

  task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic [3:0] j,
                       input logic fe, input logic [15:0] fv);
    exp_t e;
    adc_raw = a;
    dac_user = d;
    jack = j;
    force_dac_en = fe;
    force_dac_value = fv;
    for (int c = 0; c < 4; c++) begin
      e.ci[c*16 +: 16] = j[c] ? cal(c, ~a[c*16 +: 16]) : 16'h0;
      e.dout[c*16 +: 16] = fe ? fv : cal(4 + c, d[c*16 +: 16]);
    end
    sb.push_back(e);
  endtask

  task automatic pulse;
    strobe = 1'b1;
    tick;
    strobe = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] o, input logic [15:0] g);
    cfg_addr = a;
    cfg_offset = o;
    cfg_gain = g;
    cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
    off_m[a] = int'($signed(o));
    gain_m[a] = int'($signed(g));
  endtask

  task automatic test_reset;
    int seen = 0;
    reset_model();
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      seen += int'(done | busy | overrun);
    end
    total++; if (seen != 0) $display("FAIL reset_idle: %0d active cycles, need 0", seen); else passed++;
    total++; if ({cal_in, dac_out} !== 128'h0) $display("FAIL reset_out: got %h, need 0", {cal_in, dac_out}); else passed++;
    total++; if ({busy, done, overrun} !== 3'b0) $display("FAIL reset_flags: got %b, need 000", {busy, done, overrun}); else passed++;
  endtask

  task automatic test_unity;
    exp_t e;
    int lat;
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[15:0] = 16'h0FFF;
    drive(a, {$urandom, $urandom}, 4'hF, 1'b0, 16'h0);
    pulse;
    total++; if (busy !== 1'b1) $display("FAIL unity_busy_start: got %b need 1", busy); else passed++;
    wait_done(lat);
    total++; if (lat != 10) $display("FAIL unity_latency: got %0d need 10", lat); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL unity_busy_end: got %b need 0", busy); else passed++;
    total++; if (cal_in[15:0] !== 16'hF000) $display("FAIL unity_ch0: got %h need f000", cal_in[15:0]); else passed++;
    e = sb.pop_front();
    total++; if (cal_in !== e.ci) $display("FAIL unity_cal_in: got %h need %h", cal_in, e.ci); else passed++;
    total++; if (dac_out !== e.dout) $display("FAIL unity_dac_out: got %h need %h", dac_out, e.dout); else passed++;
    tick;
    total++; if (done !== 1'b0) $display("FAIL unity_done_width: got %b need 0", done); else passed++;
  endtask

  task automatic test_gain_offset;
    exp_t e;
    int lat;
    logic [63:0] d;
    cfg_write(3'd4, 16'd100, 16'd24576);
    d = {$urandom, $urandom};
    d[15:0] = 16'd1100;
    drive({$urandom, $urandom}, d, 4'hF, 1'b0, 16'h0);
    pulse;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (lat != 10) $display("FAIL gain_latency: got %0d need 10", lat); else passed++;
    total++; if (dac_out[15:0] !== 16'd1500) $display("FAIL gain_ch4: got %0d need 1500", dac_out[15:0]); else passed++;
    total++; if (dac_out !== e.dout) $display("FAIL gain_dac_out: got %h need %h", dac_out, e.dout); else passed++;
  endtask

  task automatic test_saturation;
    exp_t e;
    int lat;
    logic [63:0] d;
    cfg_write(3'd5, 16'd0, 16'd32767);
    cfg_write(3'd6, 16'd0, 16'd32767);
    d = {$urandom, $urandom};
    d[31:16] = 16'd30000;
    d[47:32] = 16'h8AD0;
    drive({$urandom, $urandom}, d, 4'hF, 1'b0, 16'h0);
    pulse;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (dac_out[31:16] !== 16'h7FFF) $display("FAIL sat_pos: got %h need 7fff", dac_out[31:16]); else passed++;
    total++; if (dac_out[47:32] !== 16'h8000) $display("FAIL sat_neg: got %h need 8000", dac_out[47:32]); else passed++;
    total++; if (dac_out !== e.dout) $display("FAIL sat_dac_out: got %h need %h", dac_out, e.dout); else passed++;
    total++; if (cal_in !== e.ci) $display("FAIL sat_cal_in: got %h need %h", cal_in, e.ci); else passed++;
  endtask

  task automatic test_jack;
    exp_t e;
    int lat;
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[31:16] = 16'h8000;
    drive(a, {$urandom, $urandom}, 4'b1101, 1'b0, 16'h0);
    pulse;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (cal_in[31:16] !== 16'h0) $display("FAIL jack_muted: got %h need 0", cal_in[31:16]); else passed++;
    total++; if (cal_in !== e.ci) $display("FAIL jack_cal_in: got %h need %h", cal_in, e.ci); else passed++;
  endtask

  task automatic test_force;
    exp_t e;
    int lat;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b1, 16'd1234);
    pulse;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (dac_out !== {4{16'd1234}}) $display("FAIL force_dac: got %h need 4x04d2", dac_out); else passed++;
    total++; if (cal_in !== e.ci) $display("FAIL force_cal_in: got %h need %h", cal_in, e.ci); else passed++;
  endtask

  task automatic test_cfg_race;
    exp_t e;
    int lat;
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[15:0] = 16'd1000;
    drive({$urandom, $urandom}, d, 4'hF, 1'b0, 16'h0);
    pulse;
    repeat (4) tick;
    cfg_addr = 3'd4;
    cfg_offset = 16'd0;
    cfg_gain = 16'd8192;
    cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
    off_m[4] = 0;
    gain_m[4] = 8192;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (dac_out[15:0] !== 16'd1350) $display("FAIL race_old_coef: got %0d need 1350", dac_out[15:0]); else passed++;
    total++; if (dac_out !== e.dout) $display("FAIL race_dac_out: got %h need %h", dac_out, e.dout); else passed++;
    drive({$urandom, $urandom}, d, 4'hF, 1'b0, 16'h0);
    pulse;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (dac_out[15:0] !== 16'd500) $display("FAIL race_new_coef: got %0d need 500", dac_out[15:0]); else passed++;
  endtask

  task automatic test_overrun;
    exp_t e;
    int lat, seen = 0;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b0, 16'h0);
    pulse;
    repeat (2) tick;
    adc_raw = {$urandom, $urandom};
    dac_user = {$urandom, $urandom};
    pulse;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_pulse: got %b need 1", overrun); else passed++;
    tick;
    total++; if (overrun !== 1'b0) $display("FAIL overrun_width: got %b need 0", overrun); else passed++;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (lat != 6) $display("FAIL overrun_latency: got %0d need 6", lat); else passed++;
    total++; if (cal_in !== e.ci) $display("FAIL overrun_cal_in: got %h need %h", cal_in, e.ci); else passed++;
    total++; if (dac_out !== e.dout) $display("FAIL overrun_dac_out: got %h need %h", dac_out, e.dout); else passed++;
    for (int i = 0; i < 15; i++) begin
      tick;
      seen += int'(done | busy);
    end
    total++; if (seen != 0) $display("FAIL overrun_second_frame: %0d active cycles need 0", seen); else passed++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b0, 16'h0);
    pulse;
    repeat (9) tick;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 4'b1011, 1'b0, 16'h0);
    strobe = 1'b1;
    tick;
    total++; if ({done, overrun} !== 2'b11) $display("FAIL b2b_commit_edge: done/overrun got %b need 11", {done, overrun}); else passed++;
    e = sb.pop_front();
    total++; if ({cal_in, dac_out} !== {e.ci, e.dout}) $display("FAIL b2b_first: got %h need %h", {cal_in, dac_out}, {e.ci, e.dout}); else passed++;
    tick;
    strobe = 1'b0;
    total++; if ({busy, overrun} !== 2'b10) $display("FAIL b2b_accept: busy/overrun got %b need 10", {busy, overrun}); else passed++;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (lat != 10) $display("FAIL b2b_latency: got %0d need 10", lat); else passed++;
    total++; if ({cal_in, dac_out} !== {e.ci, e.dout}) $display("FAIL b2b_second: got %h need %h", {cal_in, dac_out}, {e.ci, e.dout}); else passed++;
  endtask

  task automatic test_abort;
    exp_t e;
    int lat, seen = 0;
    logic [63:0] d;
    drive({$urandom, $urandom}, {$urandom, $urandom}, 4'hF, 1'b0, 16'h0);
    pulse;
    repeat (4) tick;
    rst_n = 1'b0;
    sb.delete();
    reset_model();
    for (int i = 0; i < 3; i++) begin
      tick;
      seen += int'(done | busy);
    end
    total++; if ({cal_in, dac_out} !== 128'h0) $display("FAIL abort_out: got %h need 0", {cal_in, dac_out}); else passed++;
    total++; if (seen != 0) $display("FAIL abort_flags: %0d active cycles need 0", seen); else passed++;
    rst_n = 1'b1;
    tick;
    d = {$urandom, $urandom};
    d[15:0] = 16'd1100;
    drive({$urandom, $urandom}, d, 4'hF, 1'b0, 16'h0);
    pulse;
    wait_done(lat);
    e = sb.pop_front();
    total++; if (lat != 10) $display("FAIL abort_latency: got %0d need 10", lat); else passed++;
    total++; if (dac_out[15:0] !== 16'd1100) $display("FAIL abort_table_reset: got %0d need 1100", dac_out[15:0]); else passed++;
    total++; if ({cal_in, dac_out} !== {e.ci, e.dout}) $display("FAIL abort_frame: got %h need %h", {cal_in, dac_out}, {e.ci, e.dout}); else passed++;
  endtask

  initial begin
    test_reset;
    test_unity;
    test_gain_offset;
    test_saturation;
    test_jack;
    test_force;
    test_cfg_race;
    test_overrun;
    test_back_to_back;
    test_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
